serial_addsub_ctrl: RTL and testbench

Bit-serial add/subtract controller that time-multiplexes a single one-bit full-adder cell across a WIDTH-bit operation. It sequences operands LSB-first through the cell, one bit per clock, and presents a registered WIDTH-bit result with carry-out. It sits in the arithmetic section as the low-area alternative to the ripple-carry adder/subtractor and uses a start/busy/done handshake toward its master.

---
 rtl/serial_addsub_ctrl.sv | 114 +++++++++++
 tb/tb_serial_addsub_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: one full-adder cell reused LSB-first over WIDTH clocks.
// Optional signed-overflow output is built only when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, result_q;
  logic [WIDTH-2:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q, cout_q, busy_q, done_q;

  logic             sum_d, carry_d, msbStep;
  logic [WIDTH-1:0] acc_d;

  assign sum_d   = sa_q[0] ^ sb_q[0] ^ c_q;
  assign carry_d = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
  assign msbStep = (state_q == RUN) && (cnt_q == LAST_BIT);
  // acc keeps only the WIDTH-1 newest sum bits; the current bit completes the word.
  assign acc_d   = {sum_d, acc_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            sa_q    <= a_i;
            sb_q    <= sub_i ? ~b_i : b_i;
            c_q     <= sub_i;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
          acc_q <= acc_d[WIDTH-1:1];
          c_q   <= carry_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            result_q <= acc_d;
            cout_q   <= carry_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic cmsb_q;

  // Carry into the MSB is the pre-update carry at the last step; it pairs with cout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmsb_q <= 1'b0;
    end else if (msbStep) begin
      cmsb_q <= c_q;
    end
  end

  assign ovf_o = cmsb_q ^ cout_q;
`else
  logic unusedMsb;
  assign unusedMsb = msbStep;
  assign ovf_o     = 1'b0;
`endif

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign cout_o   = cout_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl (WIDTH=8): vector table + scoreboard queue + corner sequences.
// Expected ovf follows whether SERIAL_ADDSUB_OVF_EN is defined for this build.
module tb_serial_addsub_ctrl;

`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, cout, ovf;
  logic [7:0] result;

  int   tests = 0;
  int   fails = 0;
  int   doneCount = 0;
  int   cyc = 0;
  logic prevDone = 1'b0;
  vec_t expQ[$];
  vec_t vecs[9];

  serial_addsub_ctrl #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .sub_i(sub), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .result_o(result), .cout_o(cout), .ovf_o(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic s, input logic [7:0] x, input logic [7:0] y);
    vec_t       r;
    logic [8:0] full;
    int         sx, sy, sr;
    full = s ? ({1'b0, x} + {1'b0, ~y} + 9'd1) : ({1'b0, x} + {1'b0, y});
    sx = int'($signed(x));
    sy = int'($signed(y));
    sr = s ? sx - sy : sx + sy;
    r.sub = s; r.a = x; r.b = y;
    r.res  = full[7:0];
    r.cout = full[8];
    r.ovf  = OVF_ON && (sr > 127 || sr < -128);
    return r;
  endfunction

  // Scoreboard side: every done pulse consumes one expected record.
  always @(negedge clk) begin
    if (done) begin
      vec_t e;
      doneCount++;
      checkOutput("done_single_cycle", {31'd0, prevDone}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("result", {24'd0, result}, {24'd0, e.res});
        checkOutput("cout", {31'd0, cout}, {31'd0, e.cout});
        checkOutput("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
    end
    prevDone = done;
  end

  // Drives one operation from a negedge, then waits (bounded) for done and checks busy length.
  task automatic applyStimulus(input vec_t v);
    int         busyCnt = 0;
    bit         got = 0;
    bit         held = 1;
    logic [7:0] heldRes;
    heldRes = result;
    sub = v.sub; a = v.a; b = v.b; start = 1'b1;
    expQ.push_back(v);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (done) got = 1;
      else begin
        if (busy) busyCnt++;
        if (result !== heldRes) held = 0;
        @(negedge clk);
      end
    end
    checkOutput("done_seen", {31'd0, got}, 32'd1);
    checkOutput("busy_cycles", busyCnt, 8);
    checkOutput("result_held_during_run", {31'd0, held}, 32'd1);
  endtask

  task automatic waitDone(output int when);
    bit got = 0;
    when = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (done) begin got = 1; when = cyc; end
      else @(negedge clk);
    end
    checkOutput("done_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    int   t1, t2, d0;
    vec_t v;

    vecs[0] = '{1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, OVF_ON};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, OVF_ON};
    vecs[5] = '{1'b1, 8'h20, 8'h20, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, OVF_ON};
    vecs[8] = '{1'b0, 8'h0A, 8'h0B, 8'h15, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_result", {24'd0, result}, 32'd0);
    checkOutput("reset_cout", {31'd0, cout}, 32'd0);
    checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
    end

    for (int i = 0; i < 6; i++) begin
      v = model(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      applyStimulus(v);
      @(negedge clk);
    end

    // start pulsed mid-RUN must be ignored.
    d0 = doneCount;
    sub = 1'b0; a = 8'h12; b = 8'h34; start = 1'b1;
    expQ.push_back('{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    sub = 1'b1; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(t1);
    repeat (12) @(negedge clk);
    checkOutput("one_done_for_ignored_start", doneCount - d0, 1);
    checkOutput("idle_after_ignored_start", {31'd0, busy}, 32'd0);

    // Back-to-back with start held high.
    sub = 1'b0; a = 8'h10; b = 8'h20; start = 1'b1;
    expQ.push_back('{1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0});
    @(negedge clk);
    waitDone(t1);
    a = 8'h01; b = 8'h01;
    expQ.push_back('{1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0});
    @(negedge clk);
    checkOutput("b2b_busy_no_idle", {31'd0, busy}, 32'd1);
    start = 1'b0;
    waitDone(t2);
    checkOutput("b2b_done_spacing", t2 - t1, 9);
    @(negedge clk);

    // Reset in the middle of RUN discards the operation.
    d0 = doneCount;
    sub = 1'b0; a = 8'h55; b = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrun_reset_result", {24'd0, result}, 32'd0);
    checkOutput("midrun_reset_cout", {31'd0, cout}, 32'd0);
    checkOutput("midrun_reset_ovf", {31'd0, ovf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("no_done_after_reset", doneCount - d0, 0);
    applyStimulus(vecs[8]);
    @(negedge clk);

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
